i2c_event_driver: RTL
=====================

I2C_EVENT_DRIVER -- requirements
Module: i2c_event_driver

Interface
- REQ-001: Parameter DEF_MON_EVENT_0, default 2'b00, encodes data bit 0.
- REQ-002: Parameter DEF_MON_EVENT_1, default 2'b01, encodes data bit 1.
- REQ-003: Parameter DEF_MON_EVENT_P, default 2'b10, encodes STOP.
- REQ-004: Parameter DEF_MON_EVENT_S, default 2'b11, encodes START / repeated START.
- REQ-005: i_clk  input  1  clock; all state changes occur on its rising edge.
- REQ-006: i_clr_all  input  1  reset, asynchronous, active-high.
- REQ-007: i_valid  input  1  event request valid.
- REQ-008: i_event  input  2  event code, using the DEF_MON_EVENT_* encodings.
- REQ-009: o_ready  output  1  driver can accept an event; high only in IDLE.
- REQ-010: i_t_low  input  16  minimum SCL low/high, START/STOP setup/hold and bus-free time, in i_clk cycles.
- REQ-011: i_t_su  input  16  minimum SDA-to-SCL-rise data setup, in i_clk cycles.
- REQ-012: i_scl, i_sda  input  1 each  sensed bus levels after the open-drain wired-AND.
- REQ-013: o_scl_oe, o_sda_oe  output  1 each  1 pulls the line low; 0 releases it.
- REQ-014: o_num_events  output  32  count of completed events, wraps at 2^32.
- REQ-015: o_events  output  64  completed-event history; newest event in [1:0], older events shifted left by 2.
- REQ-016: o_arb_lost, o_seq_err  output  1 each  one-cycle error pulses.
- REQ-017: o_owned  output  1  driver currently owns the bus (after START, before STOP).

Function
- REQ-018: A handshake occurs when i_valid && o_ready; i_event is latched; the FSM leaves IDLE on the next cycle.
- REQ-019: A wait of N cycles holds for exactly max(N,1) cycles in its state; i_t_low/i_t_su are sampled when the event is accepted.
- REQ-020: States: IDLE, D_LOW, D_HIGH, S_REL_SDA, S_REL_SCL, S_FALL, P_LOW, P_HIGH, P_RISE.
- REQ-021: In IDLE, o_scl_oe = o_owned and o_sda_oe is held; the bus is never left floating mid-transfer.
- REQ-022: Data bit 0/1 with o_owned=1 (D_LOW):
  - SCL held low; o_sda_oe = (bit==0) from entry.
  - wait max(i_t_low, i_t_su); then release SCL and go to D_HIGH.
- REQ-023: D_HIGH (clock stretching):
  - wait until i_scl==1, then wait i_t_low cycles;
  - then pull SCL low, event complete, return to IDLE.
- REQ-024: START with o_owned=1 (repeated START):
  - S_REL_SDA: release SDA, wait i_t_low.
  - S_REL_SCL: release SCL, wait i_scl==1, then wait i_t_low.
  - S_FALL: pull SDA low, wait i_t_low, pull SCL low, complete; o_owned=1.
- REQ-025: START with o_owned=0 enters S_REL_SCL directly; its i_t_low wait provides the bus-free time.
- REQ-026: STOP with o_owned=1:
  - P_LOW: pull SDA low, wait i_t_low.
  - P_HIGH: release SCL, wait i_scl==1, then wait i_t_low.
  - P_RISE: release SDA, wait i_t_low (t_buf); complete; o_owned=0.
- REQ-027: A data or STOP event accepted with o_owned=0 drives nothing, pulses o_seq_err, is not counted, and returns to IDLE next cycle.
- REQ-028: Arbitration: in D_HIGH with bit 1, or in S_REL_SCL, if i_scl==1 and i_sda==0:
  - pulse o_arb_lost;
  - release both lines, clear o_owned;
  - event not counted; return to IDLE.
- REQ-029: On event completion, in the same cycle: o_num_events += 1 and o_events = {o_events[61:0], code}.
- REQ-030: No timeout on clock stretching; the FSM waits in *_HIGH indefinitely while i_scl==0.

Reset
- REQ-031: While i_clr_all=1, the block SHALL hold the reset state immediately, regardless of i_clk: FSM=IDLE, o_scl_oe=0, o_sda_oe=0, o_owned=0, o_ready=0, o_num_events=0, o_events=0, o_arb_lost=0, o_seq_err=0, counters=0.
- REQ-032: o_ready SHALL rise on the first i_clk edge after i_clr_all deasserts.
- REQ-033: Reset mid-event SHALL release both lines at once and discard the event, with no count.

Verification
- REQ-034: Reset: assert i_clr_all mid-D_LOW -> o_scl_oe=o_sda_oe=0 with no clock edge; all counters 0.
- REQ-035: Basic transfer: t_low=4, t_su=2, send S,1,0,P with bus idle, i_scl/i_sda are wired-AND of the OE pins -> o_num_events=4, o_events[7:0]=8'b11_01_00_10; a passive I2C monitor reports the same 4 events with no t_low/t_su violation; o_owned=0 at end.
- REQ-036: Clock stretching: t_low=4; hold i_scl low 10 extra cycles after SCL release in D_HIGH -> SCL high phase starts counting only after i_scl=1; the bit lasts 4+10+4 cycles.
- REQ-037: Arbitration: bit 1 while an external agent forces i_sda=0 -> o_arb_lost for 1 cycle, o_scl_oe=o_sda_oe=0, o_owned=0, o_num_events unchanged.
- REQ-038: Sequence error: event 0 or P from reset -> o_seq_err 1 cycle, OE pins stay 0, o_num_events=0.
- REQ-039: Zero timing: t_low=0, t_su=0, send S,0,P -> each wait lasts 1 cycle, o_num_events=3, no hang.

Source files
------------

// File: rtl/i2c_event_driver.sv
// ============================================================================
// Module      : i2c_event_driver
// Description : I2C master bit-level driver; executes START, STOP and data-bit
//               events on open-drain SCL/SDA with clock stretching and
//               arbitration-loss detection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_event_driver #(
    parameter logic [1:0] DEF_MON_EVENT_0 = 2'b00,
    parameter logic [1:0] DEF_MON_EVENT_1 = 2'b01,
    parameter logic [1:0] DEF_MON_EVENT_P = 2'b10,
    parameter logic [1:0] DEF_MON_EVENT_S = 2'b11
) (
    input  logic        i_clk,
    input  logic        i_clr_all,
    input  logic        i_valid,
    input  logic [1:0]  i_event,
    output logic        o_ready,
    input  logic [15:0] i_t_low,
    input  logic [15:0] i_t_su,
    input  logic        i_scl,
    input  logic        i_sda,
    output logic        o_scl_oe,
    output logic        o_sda_oe,
    output logic [31:0] o_num_events,
    output logic [63:0] o_events,
    output logic        o_arb_lost,
    output logic        o_seq_err,
    output logic        o_owned
);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_D_LOW     = 4'd1,
        ST_D_HIGH    = 4'd2,
        ST_S_REL_SDA = 4'd3,
        ST_S_REL_SCL = 4'd4,
        ST_S_FALL    = 4'd5,
        ST_P_LOW     = 4'd6,
        ST_P_HIGH    = 4'd7,
        ST_P_RISE    = 4'd8
    } state_t;

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [15:0] r_t_low;
    logic [1:0]  r_code;

    logic [15:0] w_t_data;
    logic        w_bit1;
    logic        w_arb;

    // Counter preload so that a wait of N lasts max(N,1) cycles.
    function automatic logic [15:0] f_load(input logic [15:0] n);
        return (n == 16'd0) ? 16'd0 : n - 16'd1;
    endfunction

    assign w_t_data = (i_t_low > i_t_su) ? i_t_low : i_t_su;
    assign w_bit1   = (r_code == DEF_MON_EVENT_1);
    assign w_arb    = i_scl && !i_sda;

    always_ff @(posedge i_clk or posedge i_clr_all) begin
        if (i_clr_all) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 16'd0;
            r_t_low      <= 16'd0;
            r_code       <= 2'b00;
            o_ready      <= 1'b0;
            o_scl_oe     <= 1'b0;
            o_sda_oe     <= 1'b0;
            o_num_events <= 32'd0;
            o_events     <= 64'd0;
            o_arb_lost   <= 1'b0;
            o_seq_err    <= 1'b0;
            o_owned      <= 1'b0;
        end else begin
            o_arb_lost <= 1'b0;
            o_seq_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    o_ready <= 1'b1;
                    if (i_valid && o_ready) begin
                        o_ready <= 1'b0;
                        r_code  <= i_event;
                        r_t_low <= i_t_low;
                        if (i_event == DEF_MON_EVENT_S) begin
                            r_cnt    <= f_load(i_t_low);
                            o_sda_oe <= 1'b0;
                            if (o_owned) begin
                                r_state <= ST_S_REL_SDA;
                            end else begin
                                // Idle bus: the SCL-high wait doubles as bus-free time.
                                r_state  <= ST_S_REL_SCL;
                                o_scl_oe <= 1'b0;
                            end
                        end else if (!o_owned) begin
                            o_seq_err <= 1'b1;
                        end else if (i_event == DEF_MON_EVENT_P) begin
                            r_state  <= ST_P_LOW;
                            o_sda_oe <= 1'b1;
                            r_cnt    <= f_load(i_t_low);
                        end else begin
                            r_state  <= ST_D_LOW;
                            o_scl_oe <= 1'b1;
                            o_sda_oe <= (i_event == DEF_MON_EVENT_0);
                            r_cnt    <= f_load(w_t_data);
                        end
                    end
                end
                ST_D_LOW: begin
                    if (r_cnt == 16'd0) begin
                        r_state  <= ST_D_HIGH;
                        o_scl_oe <= 1'b0;
                        r_cnt    <= f_load(r_t_low);
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                ST_D_HIGH: begin
                    if (w_bit1 && w_arb) begin
                        r_state    <= ST_IDLE;
                        o_ready    <= 1'b1;
                        o_arb_lost <= 1'b1;
                        o_scl_oe   <= 1'b0;
                        o_sda_oe   <= 1'b0;
                        o_owned    <= 1'b0;
                    end else if (i_scl) begin
                        if (r_cnt == 16'd0) begin
                            r_state      <= ST_IDLE;
                            o_ready      <= 1'b1;
                            o_scl_oe     <= 1'b1;
                            o_num_events <= o_num_events + 32'd1;
                            o_events     <= {o_events[61:0], r_code};
                        end else begin
                            r_cnt <= r_cnt - 16'd1;
                        end
                    end
                end
                ST_S_REL_SDA: begin
                    if (r_cnt == 16'd0) begin
                        r_state  <= ST_S_REL_SCL;
                        o_scl_oe <= 1'b0;
                        r_cnt    <= f_load(r_t_low);
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                ST_S_REL_SCL: begin
                    if (w_arb) begin
                        r_state    <= ST_IDLE;
                        o_ready    <= 1'b1;
                        o_arb_lost <= 1'b1;
                        o_scl_oe   <= 1'b0;
                        o_sda_oe   <= 1'b0;
                        o_owned    <= 1'b0;
                    end else if (i_scl) begin
                        if (r_cnt == 16'd0) begin
                            r_state  <= ST_S_FALL;
                            o_sda_oe <= 1'b1;
                            r_cnt    <= f_load(r_t_low);
                        end else begin
                            r_cnt <= r_cnt - 16'd1;
                        end
                    end
                end
                ST_S_FALL: begin
                    if (r_cnt == 16'd0) begin
                        r_state      <= ST_IDLE;
                        o_ready      <= 1'b1;
                        o_scl_oe     <= 1'b1;
                        o_owned      <= 1'b1;
                        o_num_events <= o_num_events + 32'd1;
                        o_events     <= {o_events[61:0], r_code};
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                ST_P_LOW: begin
                    if (r_cnt == 16'd0) begin
                        r_state  <= ST_P_HIGH;
                        o_scl_oe <= 1'b0;
                        r_cnt    <= f_load(r_t_low);
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                ST_P_HIGH: begin
                    if (i_scl) begin
                        if (r_cnt == 16'd0) begin
                            r_state  <= ST_P_RISE;
                            o_sda_oe <= 1'b0;
                            r_cnt    <= f_load(r_t_low);
                        end else begin
                            r_cnt <= r_cnt - 16'd1;
                        end
                    end
                end
                ST_P_RISE: begin
                    if (r_cnt == 16'd0) begin
                        r_state      <= ST_IDLE;
                        o_ready      <= 1'b1;
                        o_owned      <= 1'b0;
                        o_num_events <= o_num_events + 32'd1;
                        o_events     <= {o_events[61:0], r_code};
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    o_scl_oe <= 1'b0;
                    o_sda_oe <= 1'b0;
                    o_owned  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
